// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: unpacks host words into an element stream for a systolic array (matrix A, then B), then flushes.
// Define LOADER_STALL_CNT_EN to count sa_valid_o & !sa_ready_i cycles on stall_cnt_o.
module matrix_stream_loader #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int word_width_p   = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    host_valid_i,
    output logic                    host_ready_o,
    input  logic [word_width_p-1:0] host_data_i,
    output logic                    sa_valid_o,
    input  logic                    sa_ready_i,
    output logic [width_p-1:0]      sa_data_o,
    input  logic                    sa_busy_i,
    output logic                    sa_flush_o,
    output logic                    phase_o,
    output logic                    done_o,
    output logic [15:0]             stall_cnt_o
);
    localparam int n_lp      = array_width_p * array_height_p;
    localparam int l_lp      = word_width_p / width_p;
    localparam int cnt_w_lp  = $clog2(n_lp + 1);
    localparam int lane_w_lp = $clog2(l_lp + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_IDLE, FLUSH, DONE} state_e;

    state_e                state_q;
    logic [word_width_p-1:0] word_q;
    logic [lane_w_lp-1:0]  lanes_q;
    logic [cnt_w_lp-1:0]   elem_q;
    logic                  phase_q;
    logic                  host_xfer;
    logic                  sa_xfer;
    logic                  last_elem;

    assign host_ready_o = state_q == LOAD && lanes_q == '0;
    assign sa_valid_o   = state_q == LOAD && lanes_q != '0;
    assign host_xfer    = host_valid_i & host_ready_o;
    assign sa_xfer      = sa_valid_o & sa_ready_i;
    assign last_elem    = elem_q == cnt_w_lp'(n_lp - 1);
    assign sa_data_o    = word_q[width_p-1:0];
    assign sa_flush_o   = state_q == FLUSH;
    assign done_o       = state_q == DONE;
    assign phase_o      = phase_q;

    // The word buffer shifts right so lane 0 of what remains is always on sa_data_o;
    // emptying it at a matrix boundary drops the unused lanes.
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            lanes_q <= '0;
            elem_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= LOAD;
                    phase_q <= 1'b0;
                    elem_q  <= '0;
                    lanes_q <= '0;
                end
                LOAD: if (host_xfer) begin
                    word_q  <= host_data_i;
                    lanes_q <= lane_w_lp'(l_lp);
                end else if (sa_xfer) begin
                    word_q  <= word_q >> width_p;
                    lanes_q <= last_elem ? '0 : lanes_q - lane_w_lp'(1);
                    elem_q  <= last_elem ? '0 : elem_q + cnt_w_lp'(1);
                    if (last_elem) begin
                        phase_q <= 1'b1;
                        if (phase_q) state_q <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: if (!sa_busy_i) state_q <= FLUSH;
                FLUSH: state_q <= DONE;
                DONE: begin
                    state_q <= IDLE;
                    phase_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end

`ifdef LOADER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i)
            stall_q <= '0;
        else if (state_q == IDLE && start_i)
            stall_q <= '0;
        else if (sa_valid_o && !sa_ready_i && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: randomized and directed checks of matrix_stream_loader against a queue-based element model.
module tb_matrix_stream_loader;
    localparam int N = 4;

    logic        clk = 0, reset_i = 0;
    logic        start = 0, hv = 0, sr = 1, busy = 0;
    logic [31:0] hd = '0;
    logic        hr, sv, flush, phase, done;
    logic [7:0]  sd;
    logic [15:0] stall;

    logic        start3 = 0;
    logic        hr3, sv3, fl3, ph3, dn3;
    logic [7:0]  sd3;
    logic [15:0] st3;

    logic        start16 = 0, hv16 = 0, sr16 = 1, busy16 = 0;
    logic [15:0] hd16 = '0;
    logic        hr16, sv16, fl16, ph16, dn16;
    logic [7:0]  sd16;
    logic [15:0] st16;

    matrix_stream_loader dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start), .host_valid_i(hv), .host_ready_o(hr),
        .host_data_i(hd), .sa_valid_o(sv), .sa_ready_i(sr), .sa_data_o(sd), .sa_busy_i(busy),
        .sa_flush_o(flush), .phase_o(phase), .done_o(done), .stall_cnt_o(stall));

    matrix_stream_loader #(.array_width_p(3), .array_height_p(1)) dut3 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start3), .host_valid_i(hv), .host_ready_o(hr3),
        .host_data_i(hd), .sa_valid_o(sv3), .sa_ready_i(sr), .sa_data_o(sd3), .sa_busy_i(busy),
        .sa_flush_o(fl3), .phase_o(ph3), .done_o(dn3), .stall_cnt_o(st3));

    matrix_stream_loader #(.word_width_p(16)) dut16 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start16), .host_valid_i(hv16), .host_ready_o(hr16),
        .host_data_i(hd16), .sa_valid_o(sv16), .sa_ready_i(sr16), .sa_data_o(sd16), .sa_busy_i(busy16),
        .sa_flush_o(fl16), .phase_o(ph16), .done_o(dn16), .stall_cnt_o(st16));

    always #5 clk = ~clk;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] exp_q[$];
    int         fill, xfer, stall_exp;
    bit         in_load = 0, prev_stall = 0;
    logic [7:0] prev_sd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: every accepted word contributes its lanes in order until the matrix holds N elements.
    task automatic observe();
        if (prev_stall) begin
            check("hold_valid", sv, 1);
            check("hold_data", sd, prev_sd);
        end
        if (in_load) begin
            check("phase", phase, xfer >= N);
            check("flush_in_load", flush, 0);
            check("done_in_load", done, 0);
        end else
            check("valid_outside_load", sv, 0);
        if (hv && hr) begin
            if (fill == N) fill = 0;
            for (int l = 0; l < 4; l++)
                if (fill < N) begin
                    exp_q.push_back(hd[8*l +: 8]);
                    fill++;
                end
        end
        if (sv && sr) begin
            if (exp_q.size() == 0) check("unexpected_elem", 1, 0);
            else check("data", sd, exp_q.pop_front());
            xfer++;
        end
        if (sv && !sr) stall_exp++;
        prev_stall = sv && !sr;
        prev_sd = sd;
    endtask

    task automatic tick();
        observe();
        @(negedge clk);
    endtask

    task automatic begin_load();
        exp_q.delete();
        fill = 0;
        xfer = 0;
        stall_exp = 0;
        prev_stall = 0;
        in_load = 1;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_load(input bit rnd, input logic [31:0] word, input bit stall3,
                            input int busy_cycles, input bit glitch);
        int stall_left;
        stall_left = stall3 ? 3 : 0;
        busy = busy_cycles > 0;
        begin_load();
        for (int c = 0; c < 600 && xfer < 2*N; c++) begin
            hv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hd = rnd ? $urandom : word;
            sr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_left > 0 && sv && xfer == 1) begin
                sr = 0;
                stall_left--;
            end
            start = glitch && c >= 3 && c < 6;
            tick();
        end
        start = 0;
        hv = 0;
        sr = 1;
        in_load = 0;
        check("load_len", xfer, 2*N);
        for (int i = 0; i < busy_cycles; i++) begin
            check("flush_while_busy", flush, 0);
            check("done_while_busy", done, 0);
            tick();
        end
        busy = 0;
        check("flush_early", flush, 0);
        tick();
        check("flush", flush, 1);
        check("done_with_flush", done, 0);
        tick();
        check("done", done, 1);
        check("flush_once", flush, 0);
        check("phase_at_done", phase, 1);
        tick();
        check("done_once", done, 0);
        check("phase_idle", phase, 0);
        check("ready_idle", hr, 0);
`ifdef LOADER_STALL_CNT_EN
        check("stall_cnt", stall, stall_exp);
`else
        check("stall_cnt", stall, 0);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, hr, 0);
        check({tag, "_valid"}, sv, 0);
        check({tag, "_data"}, sd, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        logic [31:0] words3 [2];
        logic [15:0] words16 [4];
        logic [7:0]  got[$];
        int          wi, hs;
        bit          acc;
        words3  = '{32'h04030201, 32'h08070605};
        words16 = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset_i = 1;
        tick();

        run_load(0, 32'h04030201, 0, 0, 0);
        run_load(0, 32'h04030201, 1, 0, 0);
        run_load(0, 32'h04030201, 0, 5, 0);
        run_load(1, 32'h0, 0, 2, 1);

        begin_load();
        hv = 1;
        hd = 32'h04030201;
        for (int c = 0; c < 50 && xfer < 3; c++) tick();
        check("pre_reset_count", xfer, 3);
        reset_i = 0;
        #1;
        check_zero("mid_reset");
        in_load = 0;
        prev_stall = 0;
        hv = 0;
        @(negedge clk);
        reset_i = 1;
        tick();
        run_load(0, 32'h04030201, 0, 1, 0);

        for (int r = 0; r < 6; r++) run_load(1, 32'h0, 0, $urandom_range(0, 4), 0);

        // N=3 with four lanes per word: the fourth lane of each word is dropped.
        start3 = 1;
        tick();
        start3 = 0;
        hv = 1;
        sr = 1;
        wi = 0;
        hs = 0;
        for (int c = 0; c < 100 && got.size() < 6; c++) begin
            hd = words3[wi];
            acc = hr3;
            if (sv3) got.push_back(sd3);
            tick();
            if (acc) begin
                hs++;
                wi = 1;
            end
        end
        hv = 0;
        check("n3_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++)
            check("n3_data", got[i], (i < 3) ? i + 1 : i + 2);
        check("n3_handshakes", hs, 2);
        for (int c = 0; c < 20 && !dn3; c++) tick();
        check("n3_done", dn3, 1);
        tick();

        got.delete();
        start16 = 1;
        tick();
        start16 = 0;
        hv16 = 1;
        wi = 0;
        hs = 0;
        for (int c = 0; c < 100 && got.size() < 8; c++) begin
            hd16 = words16[wi];
            acc = hr16;
            if (sv16) begin
                check("w16_phase", ph16, got.size() >= 4);
                got.push_back(sd16);
            end
            tick();
            if (acc) begin
                hs++;
                wi = (wi + 1) % 4;
            end
        end
        hv16 = 0;
        check("w16_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) check("w16_data", got[i], i + 1);
        check("w16_handshakes", hs, 4);
        for (int c = 0; c < 20 && !dn16; c++) tick();
        check("w16_done", dn16, 1);
        tick();
        check("w16_phase_idle", ph16, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
